// File: rtl/snake_pkg.sv
// Shared definitions for the snake game-flow controller: state codes and
// default grid / timing constants.
package snake_pkg;

  // Encoded values of the state output.
  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_RUNNING   = 2'd1;
  localparam logic [1:0] ST_PAUSED    = 2'd2;
  localparam logic [1:0] ST_GAME_OVER = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE      = ST_IDLE,
    S_RUNNING   = ST_RUNNING,
    S_PAUSED    = ST_PAUSED,
    S_GAME_OVER = ST_GAME_OVER
  } state_e;

  // Default playfield and step timing for the 12 MHz board build.
  localparam int DEF_GRID_SIZE_X   = 10;
  localparam int DEF_GRID_SIZE_Y   = 10;
  localparam int DEF_TICK_TIME_CLK = 12000000;
  localparam int DEF_TICK_MIN_CLK  = 3000000;
  localparam int DEF_TICK_DEC_CLK  = 500000;
  localparam int DEF_SCORE_DIGITS  = 2;

endpackage

// File: rtl/bcd_counter.sv
// Multi-digit BCD up-counter with synchronous clear; holds at all 9s.
module bcd_counter #(
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clr_i,
  input  logic                inc_i,
  output logic [4*DIGITS-1:0] count_o
);

  localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

  logic [4*DIGITS-1:0] count_q, count_d;
  logic                carry;

  // Next count: ripple a carry through the digits, stop at all 9s.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    carry   = 1'b1;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != ALL_NINES)) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (carry) begin
          if (count_q[4*i +: 4] == 4'd9) begin
            count_d[4*i +: 4] = 4'd0;
          end else begin
            count_d[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
            carry             = 1'b0;
          end
        end
      end
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so all flops update together.
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count_o = count_q;

endmodule

// File: rtl/snake_game_ctrl.sv
// Game-flow controller: run/pause/game-over FSM, accelerating step pulse,
// BCD score with high score, and a free-running seed for apple placement.
module snake_game_ctrl
  import snake_pkg::*;
#(
  parameter int GRID_SIZE_X   = DEF_GRID_SIZE_X,
  parameter int GRID_SIZE_Y   = DEF_GRID_SIZE_Y,
  parameter int TICK_TIME_CLK = DEF_TICK_TIME_CLK,
  parameter int TICK_MIN_CLK  = DEF_TICK_MIN_CLK,
  parameter int TICK_DEC_CLK  = DEF_TICK_DEC_CLK,
  parameter int SCORE_DIGITS  = DEF_SCORE_DIGITS,
  parameter int CBITS         = $clog2(TICK_TIME_CLK + 1),
  parameter int SBITS         = $clog2(GRID_SIZE_X * GRID_SIZE_Y)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      pause,
  input  logic                      key_pressed,
  input  logic                      apple_eaten,
  input  logic                      collision,
  output logic                      step,
  output logic [1:0]                state,
  output logic [4*SCORE_DIGITS-1:0] score,
  output logic [4*SCORE_DIGITS-1:0] hi_score,
  output logic [CBITS-1:0]          period,
  output logic [SBITS-1:0]          seed
);

  localparam int               CELLS     = GRID_SIZE_X * GRID_SIZE_Y;
  localparam logic [CBITS-1:0] PER_INIT  = CBITS'(TICK_TIME_CLK);
  localparam logic [CBITS-1:0] PER_MIN   = CBITS'(TICK_MIN_CLK);
  localparam logic [CBITS:0]   DEC_W     = (CBITS+1)'(TICK_DEC_CLK);
  localparam logic [CBITS:0]   MIN_W     = (CBITS+1)'(TICK_MIN_CLK);
  localparam logic [SBITS-1:0] RND_LAST  = SBITS'(CELLS - 1);

  state_e                    state_q, state_d;
  logic [CBITS-1:0]          cnt_q, cnt_d;
  logic [CBITS-1:0]          period_q, period_d;
  logic                      step_q, step_d;
  logic [4*SCORE_DIGITS-1:0] hi_q, hi_d;
  logic [SBITS-1:0]          rnd_q, seed_q;
  logic [4*SCORE_DIGITS-1:0] score_w;
  logic                      score_clr, score_inc;

  // Faster period after an apple; one extra bit catches the borrow.
  logic [CBITS:0]   per_sub;
  logic [CBITS-1:0] per_apple;
  logic             terminal;

  assign per_sub   = {1'b0, period_q} - DEC_W;
  assign per_apple = (per_sub[CBITS] || (per_sub < MIN_W)) ? PER_MIN : per_sub[CBITS-1:0];
  // ">=" so a period shortened below the running count ends the step on the next edge.
  assign terminal  = (cnt_q >= (period_q - CBITS'(1)));

  bcd_counter #(
    .DIGITS (SCORE_DIGITS)
  ) u_score (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (score_clr),
    .inc_i   (score_inc),
    .count_o (score_w)
  );

  // Next-state, tick counter, period and score control; start outranks everything.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    period_d  = period_q;
    step_d    = 1'b0;
    hi_d      = hi_q;
    score_clr = 1'b0;
    score_inc = 1'b0;
    if (start) begin
      state_d   = S_RUNNING;
      cnt_d     = '0;
      period_d  = PER_INIT;
      score_clr = 1'b1;
    end else begin
      unique case (state_q)
        S_RUNNING: begin
          if (collision) begin
            state_d = S_GAME_OVER;
            if (score_w > hi_q) hi_d = score_w;
          end else if (pause) begin
            state_d = S_PAUSED;
          end else begin
            if (terminal) begin
              cnt_d  = '0;
              step_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CBITS'(1);
            end
            if (apple_eaten) begin
              score_inc = 1'b1;
              period_d  = per_apple;
            end
          end
        end
        S_PAUSED: begin
          if (pause) state_d = S_RUNNING;
        end
        default: ;
      endcase
    end
  end

  // Game-flow registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      period_q <= PER_INIT;
      step_q   <= 1'b0;
      hi_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      step_q   <= step_d;
      hi_q     <= hi_d;
    end
  end

  // Free-running cell index, sampled into the seed on any keypress.
  always_ff @(posedge clk) begin
    if (rst) begin
      rnd_q  <= '0;
      seed_q <= '0;
    end else begin
      rnd_q <= (rnd_q == RND_LAST) ? '0 : rnd_q + SBITS'(1);
      if (key_pressed) seed_q <= rnd_q;
    end
  end

  assign step     = step_q;
  assign state    = state_q;
  assign score    = score_w;
  assign hi_score = hi_q;
  assign period   = period_q;
  assign seed     = seed_q;

endmodule

// File: doc/snake_game_ctrl.md
Name: snake_game_ctrl

Overview:
Parametrised game-flow controller for the snake game family. It replaces the fixed-period tick timer and the single-bit is_running toggle at top level.
- FSM: IDLE / RUNNING / PAUSED / GAME_OVER.
- Generates the snake step pulse with a period that shortens as apples are eaten, down to a floor.
- Keeps BCD score and high score; latches a random seed on keypress.
- Sits between key_control and snake_field; feeds the seven-segment decoders.

Parameters:
GRID_SIZE_X, 10, grid width in cells
GRID_SIZE_Y, 10, grid height in cells
TICK_TIME_CLK, 12000000, initial step period in clk cycles (>=2)
TICK_MIN_CLK, 3000000, minimum step period (2 <= TICK_MIN_CLK <= TICK_TIME_CLK)
TICK_DEC_CLK, 500000, period reduction per apple
SCORE_DIGITS, 2, BCD digits of score/high score
CBITS, $clog2(TICK_TIME_CLK+1), period/counter width (derived)
SBITS, $clog2(GRID_SIZE_X*GRID_SIZE_Y), seed width (derived)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  one-cycle pulse: (re)start game
pause  in  1  one-cycle pulse: toggle pause
key_pressed  in  1  one-cycle pulse: any key received
apple_eaten  in  1  one-cycle pulse from snake_field, head reached apple
collision  in  1  one-cycle pulse from snake_field, head hit wall/body
step  out  1  one-cycle pulse: advance snake
state  out  2  current FSM state
score  out  4*SCORE_DIGITS  BCD score, digit 0 in LSBs
hi_score  out  4*SCORE_DIGITS  BCD best score since reset
period  out  CBITS  current step period
seed  out  SBITS  random cell index for apple placement

Behaviour:
- Reset (clk edge with rst=1):
  - Outputs: state=IDLE, step=0, score=0, hi_score=0, period=TICK_TIME_CLK, seed=0.
  - Internal: tick counter cnt=0, random counter rnd=0.
- Priority per cycle: rst > start > collision > pause > apple_eaten.
- start, any state: next state RUNNING; score=0, period=TICK_TIME_CLK, cnt=0. hi_score retained.
- RUNNING:
  - cnt increments each cycle. When cnt==period-1: cnt<=0 and step<=1 on the same edge, so step is high during the following cycle.
  - First step is high during the cycle that starts TICK_TIME_CLK edges after the edge that sampled start.
- collision while RUNNING:
  - Next state GAME_OVER; cnt frozen; no step is issued on that edge.
  - If score > hi_score, hi_score<=score on the same edge.
  - If apple_eaten is also high that cycle, it is ignored.
- pause:
  - RUNNING -> PAUSED, or PAUSED -> RUNNING.
  - cnt frozen in PAUSED; counting resumes from the held value.
  - Ignored in IDLE and GAME_OVER.
- apple_eaten while RUNNING (no collision):
  - score increments in BCD with carry across digits, saturating at all 9s.
  - period <= max(period - TICK_DEC_CLK, TICK_MIN_CLK). Compute at CBITS+1 width so the subtraction cannot underflow.
  - If cnt >= new period-1, the next edge treats it as terminal: step fires, cnt<=0.
  - Ignored in other states.
- apple_eaten and step in the same cycle is legal; both take effect.
- step is never high outside RUNNING, except the single registered pulse decided on the last RUNNING edge. Any decision edge that moves the state out of RUNNING suppresses step.
- rnd:
  - Free-running 0..GRID_SIZE_X*GRID_SIZE_Y-1, wraps to 0, counts in all states.
  - On key_pressed: seed<=rnd (same edge).
- rst mid-game returns everything to reset values on the next edge regardless of other inputs.

Decomposition:
- Package snake_pkg:
  - State localparams ST_IDLE=2'd0, ST_RUNNING=2'd1, ST_PAUSED=2'd2, ST_GAME_OVER=2'd3.
  - Default grid and tick constants.
- Sub-module bcd_counter (params DIGITS): sync clear, incr, saturating at all 9s.
  - One instance for score.
  - hi_score is a plain register compared digit-wise (BCD compare equals binary compare on packed digits).

Test Plan:
- Bench params: TICK_TIME_CLK=10, TICK_MIN_CLK=4, TICK_DEC_CLK=3, GRID 4x4, SCORE_DIGITS=2.
- Reset then start pulse -> state=RUNNING; step pulses exactly 10 cycles apart; first pulse 10 edges after start; score=0x00, period=10.
- Three apple_eaten pulses, spaced -> period 10->7->4->4 (floor); score 0x00->0x01->0x02->0x03; later step spacing 4.
- pause at cnt=5, hold 20 cycles, pause again -> no step while PAUSED; next step 5 cycles after resume (with period 10). pause in IDLE leaves state=IDLE.
- collision and apple_eaten in the same cycle with score=0x09 -> state=GAME_OVER, score stays 0x09, hi_score=0x09, no further step. Then start -> score=0x00, hi_score=0x09.
- 99 apples then one more -> score saturates at 0x99; 0x09->0x10 carry checked en route.
- rnd wraps 15->0. key_pressed when rnd=15 -> seed=15. rst asserted mid-RUNNING -> all reset values next edge, hi_score=0x00.
